param_pattern_generator: RTL and testbench

Parametrised DVI test-pattern source that emits one 24-bit RGB pixel per ready/valid transfer in raster order. It succeeds the fixed 800x600 checkerboard generator, adding:
- configurable frame and tile geometry;
- four run-time-selectable patterns;
- a configurable colour-inversion period;
- start-of-frame and end-of-line markers.

It sits directly upstream of the DVI output path and feeds it at the DVI's own pace.

---
 rtl/param_pattern_generator.sv | 163 ++++++++++++++++
 tb/tb_param_pattern_generator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/param_pattern_generator.sv
// param_pattern_generator
//
// Streaming test-pattern source for the DVI output path. It emits one 24-bit
// {R,G,B} pixel per ready/valid transfer, in raster order. Frame and tile
// geometry are parameters. The pattern is chosen at run time from four
// options, and the whole picture can be colour-inverted every INVERT_PERIOD
// frames.
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   Mode         in   2   pattern select (0 checker, 1 solid, 2 gradient,
//                         3 vertical stripes); takes effect at frame start
//   VideoReady   in   1   sink accepts the pixel currently on Video
//   VideoValid   out  1   Video holds a valid pixel
//   Video        out  24  pixel colour {R,G,B}
//   StartOfFrame out  1   current pixel is (0,0)
//   EndOfLine    out  1   current pixel is the last one of its line
//
// The registered outputs always describe the pixel held in the x/y/fc/inv/m
// state registers. On a transfer, both the state and the outputs move to the
// next pixel in the same clock. This gives one pixel per clock with no
// bubbles, including at line and frame wraps.

module param_pattern_generator #(
  parameter int          WIDTH         = 800,
  parameter int          HEIGHT        = 600,
  parameter int          TILE_W        = 64,
  parameter int          TILE_H        = 32,
  parameter int          INVERT_PERIOD = 72,
  parameter logic [23:0] COLOR_A       = 24'h00CC00,
  parameter logic [23:0] COLOR_B       = 24'h00CCCC,
  parameter logic [23:0] COLOR_C       = 24'hFF9A26,
  parameter logic [23:0] COLOR_D       = 24'h9D26FF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Mode,
  input  logic        VideoReady,
  output logic        VideoValid,
  output logic [23:0] Video,
  output logic        StartOfFrame,
  output logic        EndOfLine
);

  localparam int X_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TX_SH = (TILE_W > 1) ? $clog2(TILE_W) : 0;
  localparam int TY_SH = (TILE_H > 1) ? $clog2(TILE_H) : 0;
  localparam int PC_W  = (INVERT_PERIOD > 1) ? $clog2(INVERT_PERIOD + 1) : 1;

  localparam logic [X_W-1:0]  X_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(HEIGHT - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'((INVERT_PERIOD > 0) ? INVERT_PERIOD - 1 : 0);

  logic [X_W-1:0]  x_q, x_n;
  logic [Y_W-1:0]  y_q, y_n;
  logic [15:0]     fc_q, fc_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic            inv_q, inv_n;
  logic [1:0]      m_q, m_n;

  logic            advance;
  logic            line_end;
  logic            frame_end;
  logic            tx_odd;
  logic            ty_odd;
  logic [23:0]     base_pixel;
  logic [23:0]     pixel_n;

  // Next-position logic. A transfer moves to the following raster position.
  // The last pixel of a frame also bumps the frame counter, latches the
  // requested mode, and advances the inversion period. The period counter
  // wraps one step early (at INVERT_PERIOD-1), so the toggle happens on the
  // same wrap transfer in which pc would reach INVERT_PERIOD. The new inv
  // value therefore colours pixel (0,0) of the next frame.
  always_comb begin
    x_n   = x_q;
    y_n   = y_q;
    fc_n  = fc_q;
    pc_n  = pc_q;
    inv_n = inv_q;
    m_n   = m_q;

    advance   = VideoValid && VideoReady;
    line_end  = (x_q == X_LAST);
    frame_end = line_end && (y_q == Y_LAST);

    if (advance) begin
      if (!line_end) begin
        x_n = x_q + X_W'(1);
      end else begin
        x_n = '0;
        if (!frame_end) begin
          y_n = y_q + Y_W'(1);
        end else begin
          y_n  = '0;
          fc_n = fc_q + 16'd1;
          m_n  = Mode;
          if (INVERT_PERIOD != 0) begin
            if (pc_q == PC_LAST) begin
              pc_n  = '0;
              inv_n = ~inv_q;
            end else begin
              pc_n = pc_q + PC_W'(1);
            end
          end
        end
      end
    end
  end

  // Colour of the pixel at the next position. Tile sizes are powers of two,
  // so tile parity is a single bit of the coordinate. Tiles restart at x=0
  // on every line. Partial tiles at the right and bottom edges are cut off.
  always_comb begin
    tx_odd = ((32'(x_n) >> TX_SH) & 32'd1) != 32'd0;
    ty_odd = ((32'(y_n) >> TY_SH) & 32'd1) != 32'd0;

    base_pixel = COLOR_A;
    case (m_n)
      2'd0:    base_pixel = ty_odd ? (tx_odd ? COLOR_D : COLOR_C)
                                   : (tx_odd ? COLOR_B : COLOR_A);
      2'd1:    base_pixel = COLOR_A;
      2'd2:    base_pixel = {8'(x_n), 8'(y_n), fc_n[7:0]};
      default: base_pixel = tx_odd ? COLOR_B : COLOR_A;
    endcase

    pixel_n = base_pixel ^ {24{inv_n}};
  end

  // State and output registers. Reset blanks the output and latches Mode for
  // the first frame. The cycle after reset loads pixel (0,0); the next-state
  // logic holds position there because no transfer can occur while
  // VideoValid is low. Afterwards, everything updates only on a transfer, so
  // a stalled sink sees stable data and markers.
  always_ff @(posedge clock) begin
    if (reset) begin
      VideoValid   <= 1'b0;
      Video        <= '0;
      StartOfFrame <= 1'b0;
      EndOfLine    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      fc_q         <= '0;
      pc_q         <= '0;
      inv_q        <= 1'b0;
      m_q          <= Mode;
    end else if (!VideoValid || VideoReady) begin
      VideoValid   <= 1'b1;
      Video        <= pixel_n;
      StartOfFrame <= (x_n == '0) && (y_n == '0);
      EndOfLine    <= (x_n == X_LAST);
      x_q          <= x_n;
      y_q          <= y_n;
      fc_q         <= fc_n;
      pc_q         <= pc_n;
      inv_q        <= inv_n;
      m_q          <= m_n;
    end
  end

endmodule

// File: tb/tb_param_pattern_generator.sv
// tb_param_pattern_generator
//
// Self-checking bench for param_pattern_generator. It builds two instances
// on a small 10x6 frame with 4x2 tiles. dutA inverts every 3 frames; dutB
// never inverts. Both share the same inputs.
//
// The reference model tracks only the number of transfers since reset and
// the mode latched for each frame. Every expected pixel and marker is
// derived from that count with plain arithmetic.

module tb_param_pattern_generator;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int TW = 4;
  localparam int TH = 2;
  localparam int P  = 3;
  localparam int FR = W * H;

  localparam logic [23:0] CA = 24'h00CC00;
  localparam logic [23:0] CB = 24'h00CCCC;
  localparam logic [23:0] CC = 24'hFF9A26;
  localparam logic [23:0] CD = 24'h9D26FF;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Mode;
  logic        VideoReady;

  logic        validA, sofA, eolA;
  logic [23:0] videoA;
  logic        validB, sofB, eolB;
  logic [23:0] videoB;

  int total = 0;
  int bad   = 0;

  // model state: transfers since reset, output valid, mode of each frame
  int n;
  bit mValid;
  int frameMode[$];

  always #5 clock = ~clock;

  param_pattern_generator #(
    .WIDTH(W), .HEIGHT(H), .TILE_W(TW), .TILE_H(TH), .INVERT_PERIOD(P)
  ) dutA (
    .clock(clock), .reset(reset), .Mode(Mode), .VideoReady(VideoReady),
    .VideoValid(validA), .Video(videoA), .StartOfFrame(sofA), .EndOfLine(eolA)
  );

  param_pattern_generator #(
    .WIDTH(W), .HEIGHT(H), .TILE_W(TW), .TILE_H(TH), .INVERT_PERIOD(0)
  ) dutB (
    .clock(clock), .reset(reset), .Mode(Mode), .VideoReady(VideoReady),
    .VideoValid(validB), .Video(videoB), .StartOfFrame(sofB), .EndOfLine(eolB)
  );

  // counts one comparison and reports it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (n=%0d)", tag, observed, expected, n);
    end
  endtask

  // colour of transfer index idx counted from the last reset
  function automatic logic [23:0] refPixel(input int idx, input int period);
    int x, y, f, tx, ty, md;
    logic [23:0] p;
    x  = idx % W;
    y  = (idx / W) % H;
    f  = idx / FR;
    tx = x / TW;
    ty = y / TH;
    md = frameMode[f];
    case (md)
      0:       p = ((ty % 2) == 0) ? (((tx % 2) == 0) ? CA : CB)
                                   : (((tx % 2) == 0) ? CC : CD);
      1:       p = CA;
      2:       p = {8'(x), 8'(y), 8'(f % 65536)};
      default: p = ((tx % 2) == 0) ? CA : CB;
    endcase
    if (period != 0 && ((f / period) % 2) == 1) p = ~p;
    return p;
  endfunction

  // compares both instances against the model for the current cycle
  task automatic checkAll();
    logic [23:0] expA, expB;
    logic expSof, expEol;
    expA   = mValid ? refPixel(n, P) : 24'h0;
    expB   = mValid ? refPixel(n, 0) : 24'h0;
    expSof = mValid && ((n % FR) == 0);
    expEol = mValid && ((n % W) == W - 1);
    checkOutput("validA", 32'(validA), 32'(mValid));
    checkOutput("videoA", 32'(videoA), 32'(expA));
    checkOutput("sofA",   32'(sofA),   32'(expSof));
    checkOutput("eolA",   32'(eolA),   32'(expEol));
    checkOutput("validB", 32'(validB), 32'(mValid));
    checkOutput("videoB", 32'(videoB), 32'(expB));
    checkOutput("sofB",   32'(sofB),   32'(expSof));
    checkOutput("eolB",   32'(eolB),   32'(expEol));
  endtask

  // drives one cycle of inputs, advances the model at the edge, then checks
  task automatic applyStimulus(input bit rst, input bit rdy, input logic [1:0] md);
    reset      = rst;
    VideoReady = rdy;
    Mode       = md;
    @(posedge clock);
    if (rst) begin
      mValid = 1'b0;
      n      = 0;
      frameMode.delete();
      frameMode.push_back(int'(md));
    end else if (!mValid) begin
      mValid = 1'b1;
    end else if (rdy) begin
      if (((n + 1) % FR) == 0) frameMode.push_back(int'(md));
      n++;
    end
    @(negedge clock);
    checkAll();
  endtask

  initial begin
    logic [23:0] line0 [10];
    bit          rdy, rst, didReset;
    logic [1:0]  md;
    int          dropLeft;

    line0 = '{CA, CA, CA, CA, CB, CB, CB, CB, CA, CA};
    reset      = 1'b1;
    VideoReady = 1'b0;
    Mode       = 2'd0;
    n          = 0;
    mValid     = 1'b0;
    @(negedge clock);

    // phase 1: checkerboard, sink always ready, just over ten frames
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 620; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0);
      if (n < 10) checkOutput("line0", 32'(videoA), 32'(line0[n]));
      if (n == 20) checkOutput("y2x0", 32'(videoA), 32'(CC));
      if (n == 24) checkOutput("y2x4", 32'(videoA), 32'(CD));
      if (n == 180) checkOutput("frame3inv", 32'(videoA), 32'h00FF33FF);
      if (n == 360) checkOutput("frame6back", 32'(videoA), 32'(CA));
      if ((n % FR) == 0) checkOutput("noInvP0", 32'(videoB), 32'(CA));
    end

    // phase 2: mode change mid-frame, sink stall, reset mid-frame
    applyStimulus(1'b1, 1'b0, 2'd0);
    didReset = 1'b0;
    dropLeft = 5;
    for (int i = 0; i < 400; i++) begin
      rdy = 1'b1;
      rst = 1'b0;
      md  = (n < 30) ? 2'd0 : 2'd2;
      if (mValid && n == 107 && dropLeft > 0) begin
        rdy = 1'b0;
        dropLeft--;
      end
      if (mValid && n == 263 && !didReset) begin
        rst      = 1'b1;
        md       = 2'd0;
        didReset = 1'b1;
      end
      applyStimulus(rst, rdy, md);
      if (rst) begin
        checkOutput("rstValid", 32'(validA), 32'd0);
        checkOutput("rstVideo", 32'(videoA), 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        checkOutput("postRstPix", 32'(videoA), 32'(CA));
        checkOutput("postRstSof", 32'(sofA), 32'd1);
      end
      if (mValid && n == 50) checkOutput("modeHeld", 32'(videoA), 32'(CA));
      if (mValid && n == 95) checkOutput("grad53", 32'(videoA), 32'h00050301);
      if (mValid && n == 107 && !rdy) checkOutput("stallPix", 32'(videoA), 32'h00070401);
      if (mValid && n == 108) checkOutput("afterStall", 32'(videoA), 32'h00080401);
    end

    // phase 3: random ready, random mode, occasional reset
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      md  = 2'($urandom_range(0, 3));
      applyStimulus(rst, rdy, md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
